// File: rtl/data_sram_axi_bridge_if.sv
// data_sram_axi_bridge_if: AXI3 single-beat bus between the data SRAM bridge
// (master) and an AXI3 slave.
// Ports (signals):
//   AR: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid / arready
//   R : rdata, rvalid / rready
//   AW: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid / awready
//   W : wid, wdata, wstrb, wlast, wvalid / wready
//   B : bvalid / bready
// Modports: master (bridge side), slave (memory/interconnect side).
interface data_sram_axi_bridge_if;
  // Read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // Read data channel
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  // Write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  // Write data channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // Write response channel
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rdata, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rdata, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/data_sram_axi_bridge.sv
// data_sram_axi_bridge: converts each CPU data SRAM access into one AXI3
// single-beat, word-wide read or write, stalling the pipeline until it completes.
// One transaction outstanding at a time.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   data_sram_en_i         access request (held stable while stall_o=1)
//   data_sram_wen_i[3:0]   byte write enables, 0 = read
//   data_sram_addr_i[31:0] byte address
//   data_sram_wdata_i[31:0] store data
//   data_sram_rdata_o[31:0] load data, valid in the cycle stall_o falls after a read
//   stall_o                pipeline freeze (combinational)
//   axi                    AXI3 master port (data_sram_axi_bridge_if.master)
module data_sram_axi_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_sram_en_i,
  input  logic [3:0]                   data_sram_wen_i,
  input  logic [31:0]                  data_sram_addr_i,
  input  logic [31:0]                  data_sram_wdata_i,
  output logic [31:0]                  data_sram_rdata_o,
  output logic                         stall_o,
  data_sram_axi_bridge_if.master       axi
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_A  = 3'd1;
  localparam logic [2:0] RD_D  = 3'd2;
  localparam logic [2:0] WR_AW = 3'd3;
  localparam logic [2:0] WR_B  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]        state_q,   state_d;
  logic [ADDR_W-1:0] araddr_q,  araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q,  rready_d;
  logic [ADDR_W-1:0] awaddr_q,  awaddr_d;
  logic              awvalid_q, awvalid_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0] wstrb_q,   wstrb_d;
  logic              wvalid_q,  wvalid_d;
  logic              bready_q,  bready_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              aw_done,   w_done;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    rdata_d   = rdata_q;
    // A channel counts as done once its valid has dropped or it handshakes now
    aw_done   = ~awvalid_q | axi.awready;
    w_done    = ~wvalid_q  | axi.wready;

    case (state_q)
      IDLE: begin
        if (data_sram_en_i) begin
          if (data_sram_wen_i == '0) begin
            state_d   = RD_A;
            araddr_d  = data_sram_addr_i;
            arvalid_d = 1'b1;
          end else begin
            state_d   = WR_AW;
            awaddr_d  = data_sram_addr_i;
            wdata_d   = data_sram_wdata_i;
            wstrb_d   = data_sram_wen_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      RD_A: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_D;
        end
      end
      RD_D: begin
        if (axi.rvalid) begin
          rready_d = 1'b0;
          rdata_d  = axi.rdata;
          state_d  = DONE;
        end
      end
      WR_AW: begin
        // AW and W retire independently, in either order
        if (awvalid_q && axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = WR_B;
        end
      end
      WR_B: begin
        if (axi.bvalid) begin
          bready_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  // Stall everywhere except the single DONE cycle
  assign stall_o           = data_sram_en_i & (state_q != DONE);
  assign data_sram_rdata_o = rdata_q;

  assign axi.araddr  = araddr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  // Constant sidebands: single-beat, 4-byte, INCR, normal access
  assign axi.arid    = RD_ID;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = 3'd2;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.awid    = WR_ID;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = 3'd2;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.wid     = WR_ID;
  assign axi.wlast   = 1'b1;

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// tb_data_sram_axi_bridge: self-checking bench with a delay-programmable AXI
// slave memory and a word-level reference memory for the CPU view.
module tb_data_sram_axi_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdat;
  logic [31:0] rdata_o;
  logic        stall;

  data_sram_axi_bridge_if bus();

  data_sram_axi_bridge dut (
    .clk               (clk),
    .rst               (rst),
    .data_sram_en_i    (en),
    .data_sram_wen_i   (wen),
    .data_sram_addr_i  (addr),
    .data_sram_wdata_i (wdat),
    .data_sram_rdata_o (rdata_o),
    .stall_o           (stall),
    .axi               (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Default memory content for never-written words
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5_5A5A;
  endfunction

  // ---------------- AXI slave memory ----------------
  logic [31:0] smem [int unsigned];
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic noise = 1'b0;
  logic nz_arready, nz_rvalid, nz_awready, nz_wready, nz_bvalid;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic r_pend, b_pend, aw_got, w_got;
  logic [31:0] r_data_q, aw_addr_s, w_data_s;
  logic [3:0]  w_strb_s;

  int n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0, cyc = 0;
  int r_hs_cyc = 0, aw_start_cyc = 0, w_start_cyc = 0;
  logic [31:0] last_ar_addr = '0, last_aw_addr = '0;
  logic [3:0]  last_wstrb = '0;
  logic arv_p, arr_p, awv_p, awr_p, wv_p, wr_p;
  logic [31:0] ara_p, awa_p, wd_p;
  logic [3:0]  ws_p;

  function automatic logic [31:0] smem_rd(input logic [31:0] a);
    if (smem.exists(a >> 2)) return smem[a >> 2];
    return dflt(a);
  endfunction

  assign bus.arready = noise ? nz_arready : (bus.arvalid && ar_cnt >= ar_dly);
  assign bus.rvalid  = noise ? nz_rvalid  : (r_pend && r_cnt >= r_dly);
  assign bus.rdata   = r_data_q;
  assign bus.awready = noise ? nz_awready : (bus.awvalid && aw_cnt >= aw_dly);
  assign bus.wready  = noise ? nz_wready  : (bus.wvalid && w_cnt >= w_dly);
  assign bus.bvalid  = noise ? nz_bvalid  : (b_pend && b_cnt >= b_dly);

  always @(posedge clk or posedge rst) begin
    logic aw_now, w_now;
    logic [31:0] wa, wd, word;
    logic [3:0]  ws;
    if (rst) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      r_data_q <= '0; aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
      nz_arready <= 1'b0; nz_rvalid <= 1'b0; nz_awready <= 1'b0;
      nz_wready <= 1'b0; nz_bvalid <= 1'b0;
      arv_p = 1'b0; arr_p = 1'b0; awv_p = 1'b0; awr_p = 1'b0; wv_p = 1'b0; wr_p = 1'b0;
      ara_p = '0; awa_p = '0; wd_p = '0; ws_p = '0;
    end else begin
      cyc++;
      nz_arready <= 1'($urandom_range(0, 1));
      nz_rvalid  <= 1'($urandom_range(0, 1));
      nz_awready <= 1'($urandom_range(0, 1));
      nz_wready  <= 1'($urandom_range(0, 1));
      nz_bvalid  <= 1'($urandom_range(0, 1));

      // Valid/payload must hold until handshake
      if (arv_p && !arr_p) begin
        check_eq("ar_hold_valid", 32'(bus.arvalid), 32'd1);
        check_eq("ar_hold_addr", bus.araddr, ara_p);
      end
      if (awv_p && !awr_p) begin
        check_eq("aw_hold_valid", 32'(bus.awvalid), 32'd1);
        check_eq("aw_hold_addr", bus.awaddr, awa_p);
      end
      if (wv_p && !wr_p) begin
        check_eq("w_hold_valid", 32'(bus.wvalid), 32'd1);
        check_eq("w_hold_data", bus.wdata, wd_p);
        check_eq("w_hold_strb", 32'(bus.wstrb), 32'(ws_p));
      end
      if (bus.awvalid && !awv_p) aw_start_cyc = cyc;
      if (bus.wvalid && !wv_p)   w_start_cyc  = cyc;
      arv_p = bus.arvalid; arr_p = bus.arready; ara_p = bus.araddr;
      awv_p = bus.awvalid; awr_p = bus.awready; awa_p = bus.awaddr;
      wv_p  = bus.wvalid;  wr_p  = bus.wready;  wd_p = bus.wdata; ws_p = bus.wstrb;

      // AR / R
      if (bus.arvalid && bus.arready) begin
        n_ar++;
        last_ar_addr = bus.araddr;
        check_eq("arsize", 32'(bus.arsize), 32'd2);
        check_eq("arlen", 32'(bus.arlen), 32'd0);
        check_eq("arburst", 32'(bus.arburst), 32'd1);
        check_eq("arid", 32'(bus.arid), 32'd0);
        check_eq("ar_lock_cache_prot", 32'({bus.arlock, bus.arcache, bus.arprot}), 32'd0);
        ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= 0;
        r_data_q <= smem_rd(bus.araddr);
      end else if (bus.arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (bus.rvalid && bus.rready) begin
        n_r++;
        r_hs_cyc = cyc;
        r_pend <= 1'b0;
      end else if (r_pend && !bus.rvalid) begin
        r_cnt <= r_cnt + 1;
      end

      // AW / W / B
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      if (aw_now) begin
        n_aw++;
        last_aw_addr = bus.awaddr;
        check_eq("awsize", 32'(bus.awsize), 32'd2);
        check_eq("awid", 32'(bus.awid), 32'd1);
        check_eq("awlen", 32'(bus.awlen), 32'd0);
        aw_cnt <= 0; aw_addr_s <= bus.awaddr;
      end else if (bus.awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (w_now) begin
        n_w++;
        last_wstrb = bus.wstrb;
        check_eq("wid", 32'(bus.wid), 32'd1);
        check_eq("wlast", 32'(bus.wlast), 32'd1);
        w_cnt <= 0; w_data_s <= bus.wdata; w_strb_s <= bus.wstrb;
      end else if (bus.wvalid) begin
        w_cnt <= w_cnt + 1;
      end
      if ((aw_got || aw_now) && (w_got || w_now)) begin
        wa = aw_now ? bus.awaddr : aw_addr_s;
        wd = w_now ? bus.wdata : w_data_s;
        ws = w_now ? bus.wstrb : w_strb_s;
        word = smem_rd(wa);
        for (int i = 0; i < 4; i++) if (ws[i]) word[8*i +: 8] = wd[8*i +: 8];
        smem[wa >> 2] = word;
        b_pend <= 1'b1; b_cnt <= 0;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (aw_now) aw_got <= 1'b1;
        if (w_now)  w_got  <= 1'b1;
      end
      if (bus.bvalid && bus.bready) begin
        n_b++;
        b_pend <= 1'b0;
      end else if (b_pend && !bus.bvalid) begin
        b_cnt <= b_cnt + 1;
      end
    end
  end

  // ---------------- Reference model (CPU view) ----------------
  logic [31:0] model_mem [int unsigned];
  logic [31:0] exp_rdata = '0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(a >> 2)) return model_mem[a >> 2];
    return dflt(a);
  endfunction

  // One CPU access; exp_hi < 0 skips the stall-length check
  task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        input int exp_hi);
    int hi, ar0, r0, aw0, w0, b0;
    logic [31:0] word;
    ar0 = n_ar; r0 = n_r; aw0 = n_aw; w0 = n_w; b0 = n_b;
    en = 1'b1; wen = w; addr = a; wdat = d;
    hi = 0;
    while (1) begin
      @(negedge clk);
      if (!stall) break;
      hi++;
      if (hi > 300) begin
        check_eq("stall_timeout", 32'(stall), 32'd0);
        break;
      end
    end
    if (w == 4'b0000) begin
      exp_rdata = model_rd(a);
      check_eq("rd_data", rdata_o, exp_rdata);
      check_eq("rd_n_ar", 32'(n_ar - ar0), 32'd1);
      check_eq("rd_n_r", 32'(n_r - r0), 32'd1);
      check_eq("rd_n_aw", 32'(n_aw - aw0), 32'd0);
    end else begin
      word = model_rd(a);
      for (int i = 0; i < 4; i++) if (w[i]) word[8*i +: 8] = d[8*i +: 8];
      model_mem[a >> 2] = word;
      check_eq("wr_rdata_kept", rdata_o, exp_rdata);
      check_eq("wr_n_aw", 32'(n_aw - aw0), 32'd1);
      check_eq("wr_n_w", 32'(n_w - w0), 32'd1);
      check_eq("wr_n_b", 32'(n_b - b0), 32'd1);
      check_eq("wr_n_ar", 32'(n_ar - ar0), 32'd0);
    end
    if (exp_hi >= 0) check_eq("stall_len", 32'(hi), 32'(exp_hi));
    @(posedge clk); #1;
    en = 1'b0; wen = '0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_stall"}, 32'(stall), 32'd0);
    check_eq({tag, "_valids"}, 32'({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}), 32'd0);
    check_eq({tag, "_rdata"}, rdata_o, exp_rdata);
  endtask

  initial begin
    int t;
    rst = 1'b1; en = 1'b0; wen = '0; addr = '0; wdat = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outputs", 32'({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, stall}), 32'd0);
    check_eq("rst_araddr", bus.araddr, 32'd0);
    check_eq("rst_awaddr", bus.awaddr, 32'd0);
    check_eq("rst_wdata", bus.wdata, 32'd0);
    check_eq("rst_wstrb", 32'(bus.wstrb), 32'd0);
    check_eq("rst_rdata", rdata_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait read of a preloaded word
    smem[32'h1FC0_0100 >> 2] = 32'hDEAD_BEEF;
    model_mem[32'h1FC0_0100 >> 2] = 32'hDEAD_BEEF;
    access(4'b0000, 32'h1FC0_0100, 32'h0, 3);
    check_eq("t1_rdata", rdata_o, 32'hDEAD_BEEF);
    check_eq("t1_araddr", last_ar_addr, 32'h1FC0_0100);

    // Byte store, W accepted two cycles ahead of AW
    aw_dly = 2; w_dly = 0;
    access(4'b0100, 32'h0000_0200, 32'h00AB_0000, 5);
    check_eq("t2_wstrb", 32'(last_wstrb), 32'h4);
    check_eq("t2_aw_w_together", 32'(aw_start_cyc), 32'(w_start_cyc));
    aw_dly = 0;
    access(4'b0000, 32'h0000_0200, 32'h0, 3);

    // Slave holds off arready for five cycles
    ar_dly = 5;
    access(4'b0000, 32'h0000_0300, 32'h0, 8);
    ar_dly = 0;

    // Read immediately followed by a write
    access(4'b0000, 32'h0000_0100, 32'h0, 3);
    check_eq("t4_ar_addr", last_ar_addr, 32'h0000_0100);
    access(4'b1111, 32'h0000_0104, 32'h1234_5678, 3);
    check_eq("t4_aw_addr", last_aw_addr, 32'h0000_0104);
    check_eq("t4_gap", 32'(aw_start_cyc - r_hs_cyc >= 3), 32'd1);
    access(4'b0000, 32'h0000_0104, 32'h0, 3);

    // Asynchronous reset while waiting in the data phase of a read
    r_dly = 20;
    en = 1'b1; wen = '0; addr = 32'h0000_0400; wdat = '0;
    t = 0;
    while (!bus.rready && t < 50) begin @(negedge clk); t++; end
    check_eq("t5_reached_rd", 32'(bus.rready), 32'd1);
    #2;
    rst = 1'b1; en = 1'b0;
    #1;
    exp_rdata = '0;
    check_eq("t5_async_rready", 32'(bus.rready), 32'd0);
    check_eq("t5_async_araddr", bus.araddr, 32'd0);
    check_quiet("t5_in_rst");
    @(posedge clk); #1;
    rst = 1'b0; r_dly = 0;
    repeat (3) begin @(negedge clk); check_quiet("t5_after"); end
    @(posedge clk); #1;

    // Idle with slave noise
    access(4'b0000, 32'h0000_0200, 32'h0, 3);
    noise = 1'b1;
    repeat (10) begin @(negedge clk); check_quiet("t6_noise"); end
    @(posedge clk); #1;
    noise = 1'b0;
    @(posedge clk); #1;

    // Randomized mixed traffic with random slave delays
    for (int k = 0; k < 40; k++) begin
      logic [3:0] w;
      logic [31:0] a;
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3);
      w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      a = 32'h0000_1000 + 32'($urandom_range(0, 7)) * 32'd4;
      access(w, a, $urandom, -1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
